// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch key debounce, 10 ms tick divider and run/pause FSM; lap hold under STOPWATCH_LAP_EN
module stopwatch_ctrl #(
  parameter int TICK_DIV        = 500000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_reset,
  input  logic key_start_pause,
  input  logic key_display_stop,
  output logic count_en,
  output logic count_clr,
  output logic disp_load,
  output logic running,
  output logic frozen
);

  localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  // Key index 0 = reset, 1 = start/pause, 2 = display/stop (lap build only).
`ifdef STOPWATCH_LAP_EN
  localparam int NKEYS = 3;
  logic [NKEYS-1:0] w_keys;
  assign w_keys = {key_display_stop, key_start_pause, key_reset};
`else
  localparam int NKEYS = 2;
  logic [NKEYS-1:0] w_keys;
  logic             w_unused_key;
  assign w_keys       = {key_start_pause, key_reset};
  assign w_unused_key = key_display_stop;
`endif

  logic [NKEYS-1:0] r_sync1;
  logic [NKEYS-1:0] r_sync2;
  logic [NKEYS-1:0] r_level;
  logic [NKEYS-1:0] r_press;
  logic [CW-1:0]    r_dbcnt [NKEYS];

  logic [DW-1:0] r_div;
  logic          w_tick;
  logic          w_press_reset;
  logic          w_press_sp;

  state_t r_state;
  logic   r_running;
  logic   r_count_en;
  logic   r_count_clr;
  logic   r_disp_load;

  assign w_press_reset = r_press[0];
  assign w_press_sp    = r_press[1];
  assign w_tick        = (r_div == DIV_LAST);

  // Synchronize each raw key, accept a new level after DEBOUNCE_CYCLES differing samples, pulse on press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_level <= '1;
      r_press <= '0;
      for (int k = 0; k < NKEYS; k++) begin
        r_dbcnt[k] <= '0;
      end
    end else begin
      r_sync1 <= w_keys;
      r_sync2 <= r_sync1;
      r_press <= '0;
      for (int k = 0; k < NKEYS; k++) begin
        if (r_sync2[k] == r_level[k]) begin
          r_dbcnt[k] <= '0;
        end else if (r_dbcnt[k] == DB_LAST) begin
          r_level[k] <= r_sync2[k];
          r_dbcnt[k] <= '0;
          r_press[k] <= ~r_sync2[k];
        end else begin
          r_dbcnt[k] <= r_dbcnt[k] + 1'b1;
        end
      end
    end
  end

  // Tick divider: restarts on reset key and on a fresh start, holds its partial period while paused.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_press_reset || (r_state == S_IDLE && w_press_sp)) begin
      r_div <= '0;
    end else if (r_state != S_PAUSE) begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic w_press_ds;
  logic r_frozen;
  logic r_frozen_d;
  assign w_press_ds = r_press[2];
`endif

  // Run/pause/idle FSM with registered strobes; reset key wins over start/pause in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_running   <= 1'b0;
      r_count_en  <= 1'b0;
      r_count_clr <= 1'b0;
      r_disp_load <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      r_frozen    <= 1'b0;
      r_frozen_d  <= 1'b0;
`endif
    end else begin
      r_count_en  <= w_tick && (r_state == S_RUN) && !w_press_reset;
      r_count_clr <= w_press_reset;
`ifdef STOPWATCH_LAP_EN
      r_disp_load <= (r_count_en && !r_frozen) || r_count_clr || (r_frozen_d && !r_frozen);
      r_frozen_d  <= r_frozen;
`else
      r_disp_load <= r_count_en || r_count_clr;
`endif
      if (w_press_reset) begin
        r_state   <= S_IDLE;
        r_running <= 1'b0;
`ifdef STOPWATCH_LAP_EN
        r_frozen  <= 1'b0;
`endif
      end else begin
        if (w_press_sp) begin
          case (r_state)
            S_IDLE: begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end
            S_RUN: begin
              r_state   <= S_PAUSE;
              r_running <= 1'b0;
            end
            S_PAUSE: begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end
            default: begin
              r_state   <= S_IDLE;
              r_running <= 1'b0;
            end
          endcase
        end
`ifdef STOPWATCH_LAP_EN
        if (w_press_ds) begin
          r_frozen <= ~r_frozen;
        end
`endif
      end
    end
  end

  assign count_en  = r_count_en;
  assign count_clr = r_count_clr;
  assign disp_load = r_disp_load;
  assign running   = r_running;
`ifdef STOPWATCH_LAP_EN
  assign frozen    = r_frozen;
`else
  assign frozen    = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl with a cycle-level behavioural model
module tb_stopwatch_ctrl;

  localparam int T = 10;
  localparam int D = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic clk;
  logic rst_n;
  logic key_reset;
  logic key_start_pause;
  logic key_display_stop;
  logic count_en;
  logic count_clr;
  logic disp_load;
  logic running;
  logic frozen;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  stopwatch_ctrl #(
    .TICK_DIV(T),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_reset(key_reset),
    .key_start_pause(key_start_pause),
    .key_display_stop(key_display_stop),
    .count_en(count_en),
    .count_clr(count_clr),
    .disp_load(disp_load),
    .running(running),
    .frozen(frozen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit q_sync [3][$];
  bit hist   [3][$];
  bit lvl    [3];
  bit prs    [3];
  int m_state;
  int m_phase;
  bit m_ce, m_clr, m_dl, m_fz, m_fz_prev;
  bit m_valid = 1'b0;

  function automatic bit raw_key(input int k);
    case (k)
      0:       return key_reset;
      1:       return key_start_pause;
      default: return key_display_stop;
    endcase
  endfunction

  always @(posedge clk) begin
    bit o_ce, o_clr, o_fz, o_fzp, tick, s, all_diff;
    bit o_pr [3];
    int o_state;
    cyc++;
    m_valid = 1'b1;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        q_sync[k].delete();
        q_sync[k].push_back(1'b1);
        q_sync[k].push_back(1'b1);
        hist[k].delete();
        lvl[k] = 1'b1;
        prs[k] = 1'b0;
      end
      m_state = M_IDLE;
      m_phase = 0;
      m_ce = 0; m_clr = 0; m_dl = 0; m_fz = 0; m_fz_prev = 0;
    end else begin
      o_state = m_state;
      o_ce = m_ce; o_clr = m_clr; o_fz = m_fz; o_fzp = m_fz_prev;
      for (int k = 0; k < 3; k++) o_pr[k] = prs[k];
      tick = ((m_phase % T) == T - 1);
      m_ce = tick && (o_state == M_RUN) && !o_pr[0];
      m_dl = (o_ce && !o_fz) || o_clr || (o_fzp && !o_fz);
      m_fz_prev = o_fz;
      m_clr = o_pr[0];
      if (o_pr[0]) begin
        m_state = M_IDLE;
        m_fz = 1'b0;
        m_phase = 0;
      end else begin
        if (o_pr[1]) begin
          if (o_state == M_IDLE) m_state = M_RUN;
          else if (o_state == M_RUN) m_state = M_PAUSE;
          else m_state = M_RUN;
        end
`ifdef STOPWATCH_LAP_EN
        if (o_pr[2]) m_fz = !o_fz;
`endif
        if (o_pr[1] && o_state == M_IDLE) m_phase = 0;
        else if (o_state != M_PAUSE) m_phase++;
      end
      for (int k = 0; k < 3; k++) begin
        s = q_sync[k].pop_front();
        q_sync[k].push_back(raw_key(k));
        prs[k] = 1'b0;
        hist[k].push_back(s);
        if (hist[k].size() > D) void'(hist[k].pop_front());
        if (hist[k].size() == D) begin
          all_diff = 1'b1;
          foreach (hist[k][i]) if (hist[k][i] == lvl[k]) all_diff = 1'b0;
          if (all_diff) begin
            lvl[k] = !lvl[k];
            prs[k] = !lvl[k];
            hist[k].delete();
          end
        end
      end
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("running",   int'(running),   int'(m_state == M_RUN));
      chk("count_en",  int'(count_en),  int'(m_ce));
      chk("count_clr", int'(count_clr), int'(m_clr));
      chk("disp_load", int'(disp_load), int'(m_dl));
      chk("frozen",    int'(frozen),    int'(m_fz));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic bit sig(input int which);
    case (which)
      0:       return running;
      1:       return count_en;
      2:       return count_clr;
      3:       return disp_load;
      default: return frozen;
    endcase
  endfunction

  task automatic set_key(input int k, input bit v);
    case (k)
      0:       key_reset = v;
      1:       key_start_pause = v;
      default: key_display_stop = v;
    endcase
  endtask

  task automatic tap(input int k);
    fork
      begin
        set_key(k, 1'b0);
        repeat (8) @(negedge clk);
        set_key(k, 1'b1);
      end
    join_none
  endtask

  task automatic wait_lvl(input int which, input bit lv, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sig(which) != lv && n < limit);
    chk($sformatf("wait_sig%0d_reached", which), int'(sig(which)), int'(lv));
  endtask

  task automatic window(input int n, output int strobes, output int run_seen);
    strobes = 0;
    run_seen = 0;
    repeat (n) begin
      @(negedge clk);
      strobes += int'(count_en) + int'(count_clr) + int'(disp_load);
      run_seen += int'(running);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, t_run, t0, t_ce, st, rs, acc, racc;
    rst_n = 1'b0;
    key_reset = 1'b1;
    key_start_pause = 1'b1;
    key_display_stop = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'(running) + int'(count_en) + int'(count_clr) + int'(disp_load) + int'(frozen), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset then start: running at +7, first count_en 10 later, period 10, disp_load follows.
    c0 = cyc;
    tap(1);
    wait_lvl(0, 1'b1, 30);
    chk("s1_run_latency", cyc - c0, 7);
    t_run = cyc;
    wait_lvl(1, 1'b1, 30);
    chk("s1_first_tick", cyc - t_run, 10);
    t0 = cyc;
    @(negedge clk);
    chk("s1_load_after_tick", int'(disp_load), 1);
    wait_lvl(1, 1'b1, 30);
    chk("s1_tick_period", cyc - t0, 10);
    @(negedge clk);
    chk("s1_load_after_tick2", int'(disp_load), 1);

    // Pause 3 cycles after a count_en, then resume: first count_en after 10-3.
    wait_lvl(1, 1'b1, 30);
    t_ce = cyc;
    repeat (6) @(negedge clk);
    tap(1);
    wait_lvl(0, 1'b0, 30);
    chk("s3_pause_edge", cyc - t_ce, 13);
    window(25, st, rs);
    chk("s3_no_count_in_pause", st, 0);
    tap(1);
    wait_lvl(0, 1'b1, 30);
    t_run = cyc;
    wait_lvl(1, 1'b1, 30);
    chk("s3_resume_tick", cyc - t_run, 7);
    @(negedge clk);
    chk("s3_load_after_resume_tick", int'(disp_load), 1);

    // Simultaneous reset and start/pause in RUN.
    repeat (3) @(negedge clk);
    tap(0);
    tap(1);
    wait_lvl(2, 1'b1, 30);
    chk("s4_running_at_clr", int'(running), 0);
    chk("s4_no_count_at_clr", int'(count_en), 0);
    @(negedge clk);
    chk("s4_load_after_clr", int'(disp_load), 1);
    chk("s4_clr_single", int'(count_clr), 0);
    window(30, st, rs);
    chk("s4_quiet_strobes", st, 0);
    chk("s4_quiet_running", rs, 0);

    // Bounce rejection in IDLE.
    acc = 0;
    racc = 0;
    for (int i = 0; i < 10; i++) begin
      key_start_pause = 1'b0;
      window(2, st, rs);
      acc += st; racc += rs;
      key_start_pause = 1'b1;
      window(2, st, rs);
      acc += st; racc += rs;
    end
    window(20, st, rs);
    acc += st; racc += rs;
    chk("s2_bounce_strobes", acc, 0);
    chk("s2_bounce_running", racc, 0);

    // Lap.
    tap(1);
    wait_lvl(0, 1'b1, 30);
    repeat (3) @(negedge clk);
    tap(2);
`ifdef STOPWATCH_LAP_EN
    wait_lvl(4, 1'b1, 30);
    wait_lvl(1, 1'b1, 30);
    @(negedge clk);
    chk("s5_frozen_no_load", int'(disp_load), 0);
    repeat (12) @(negedge clk);
    tap(2);
    wait_lvl(4, 1'b0, 30);
    @(negedge clk);
    chk("s5_unfreeze_load", int'(disp_load), 1);
`else
    repeat (20) @(negedge clk);
    chk("s5_frozen_tied", int'(frozen), 0);
    wait_lvl(1, 1'b1, 30);
    @(negedge clk);
    chk("s5_load_follows_tick", int'(disp_load), 1);
    repeat (12) @(negedge clk);
    tap(2);
    repeat (20) @(negedge clk);
    chk("s5_frozen_tied2", int'(frozen), 0);
    wait_lvl(1, 1'b1, 30);
    @(negedge clk);
    chk("s5_load_follows_tick2", int'(disp_load), 1);
`endif
    repeat (15) @(negedge clk);

    // rst_n mid-run for one cycle.
    chk("s6_running_before", int'(running), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("s6_outputs_in_reset", int'(running) + int'(count_en) + int'(count_clr) + int'(disp_load) + int'(frozen), 0);
    rst_n = 1'b1;
    window(25, st, rs);
    chk("s6_quiet_strobes", st, 0);
    chk("s6_quiet_running", rs, 0);
    c0 = cyc;
    tap(1);
    wait_lvl(0, 1'b1, 30);
    chk("s6_restart_latency", cyc - c0, 7);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
